alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Execute-stage result/flag stage directly downstream of the 32-bit carry-lookahead adder. Consumes the adder's `sum`/`cout` with the original operands and op code, derives MIPS result, zero/negative/carry/overflow flags and set-less-than values, and buffers them in a 2-entry skid queue with valid/ready handshake toward the EX/MEM register. With the trap option, signed overflow halts intake until the pipeline flushes.

## Interface
- `WIDTH`, 32: datapath width; adder sum and operands.
- `TAG_W`, 5: destination-register tag width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  block accepts this cycle.
- `in_op`  in  3  000 ADD, 001 ADDU, 010 SUB, 011 SUBU, 100 SLT, 101 SLTU, 110/111 illegal.
- `in_a`  in  WIDTH  operand A (adder `d1`).
- `in_b`  in  WIDTH  operand B before inversion (adder `d2`).
- `in_sum`  in  WIDTH  adder sum, aligned with `in_a`/`in_b`.
- `in_cout`  in  1  adder carry-out.
- `in_tag`  in  TAG_W  destination register.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_result`, `out_tag`  out  WIDTH, TAG_W  head result, tag.
- `out_zero`, `out_neg`, `out_carry`, `out_ovf`  out  1 each  head flags.
- `out_wen`  out  1  register write enable for head entry.
- `out_illegal`  out  1  head op was 110/111.
- `out_trap`  out  1  head entry raised overflow trap.

## Operation
- Sub-type ops (SUB, SUBU, SLT, SLTU): upstream drives adder with cin=1, so `in_sum` = A − B mod 2^32.
- Overflow: add ops `ovf = (a[31]==b[31]) && (sum[31]!=a[31])`; sub ops `ovf = (a[31]!=b[31]) && (sum[31]!=a[31])`. Reported only for ADD/SUB; 0 for ADDU/SUBU/SLT/SLTU.
- Carry: add ops `carry = cout`; sub ops `carry = ~cout` (borrow).
- Result: ADD/ADDU/SUB/SUBU → `in_sum`; SLT → `{31'b0, sum[31]^ovf_sub}`; SLTU → `{31'b0, ~cout}`; illegal → 0, `out_illegal`=1, `out_wen`=0.
- `zero` = (result==0), `neg` = result[31], computed on the final result.
- Queue: 2 entries, in-order. Push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- `in_ready` = (count<2) && state==RUN && !flush. `out_valid` = (count!=0).
- Count 1 with push+pop: count stays 1, new entry becomes head next cycle. Count 2: no push possible. Count 0: pop ignored.
- FSM RUN/HALT (only with trap option): RUN→HALT in the cycle a trapping entry is pushed; HALT keeps `in_ready`=0, queued entries still drain; HALT→RUN only on `flush`.
- `flush`: priority over push/pop; next cycle count=0, state=RUN, pushes that cycle discarded.
- Reset (`rst_n`=0 at clk edge): count=0, state=RUN; all outputs 0 (`out_valid`, `out_result`, `out_tag`, flags, `out_wen`, `out_illegal`, `out_trap`); `in_ready` 0 during reset, 1 the cycle after. Reset mid-transfer drops all entries.

## Timing
- Latency 1: entry pushed at edge N is visible on outputs after edge N (cycle N+1) if queue was empty.
- Throughput 1 entry/cycle while `out_ready` held high.
- Outputs driven from queue registers only; no combinational path from `in_*` to `out_*`. `in_ready` depends on registered state and `flush` only, never on `out_ready`.
- Output fields are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `ALU_OVF_TRAP_EN` defined: ADD/SUB with ovf=1 set `out_trap`=1, `out_wen`=0 for that entry, and move FSM to HALT.
- Undefined: `out_trap` tied 0, no HALT state, overflowing ADD/SUB write normally (`out_wen`=1), `out_ovf` still reported.

## Test plan
- ADD 0x7FFFFFFF+1 (sum 0x80000000, cout 0) → result 0x80000000, ovf=1, neg=1, carry=0; with macro trap=1, wen=0, in_ready low until flush.
- SUBU 5−5 (sum 0, cout 1) → result 0, zero=1, carry=0, ovf=0, wen=1.
- SLT A=0xFFFFFFFF, B=1 → result 1; SLTU same operands → result 0.
- out_ready=0, push 3 entries back-to-back → in_ready drops after 2nd push; raise out_ready → entries emerge in order, one per cycle.
- Count=1, push and pop same cycle for 10 cycles → out_valid stays 1, each entry appears exactly once, in order.
- Queue holds 2 entries, assert flush (then separately rst_n=0) → next cycle out_valid=0, all outputs 0 after reset, in_ready=1.

Source files
------------

// File: rtl/alu_result_stage.sv
// Execute-stage result/flag derivation behind the CLA adder, buffered in a 2-entry skid queue.
// Optional overflow trap (halts intake until flush) enabled by defining ALU_OVF_TRAP_EN.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_wen,
  output logic             out_illegal,
  output logic             out_trap
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDU = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_SUBU = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             wen;
    logic             illegal;
    logic             trap;
  } entry_t;

  entry_t     new_e;
  entry_t     q0_q, q0_d, q1_q, q1_d;
  logic [1:0] count_q, count_d;
  logic       run;
  logic       push, pop;
  logic       a_msb, b_msb, s_msb;
  logic       ovf_add, ovf_sub;

  assign a_msb   = in_a[WIDTH-1];
  assign b_msb   = in_b[WIDTH-1];
  assign s_msb   = in_sum[WIDTH-1];
  assign ovf_add = (a_msb == b_msb) && (s_msb != a_msb);
  assign ovf_sub = (a_msb != b_msb) && (s_msb != a_msb);

  // Sub-type ops arrive with cin=1, so carry-out is inverted borrow.
  always_comb begin
    new_e     = '0;
    new_e.tag = in_tag;
    new_e.wen = 1'b1;
    case (in_op)
      OP_ADD: begin
        new_e.result = in_sum;
        new_e.carry  = in_cout;
        new_e.ovf    = ovf_add;
      end
      OP_ADDU: begin
        new_e.result = in_sum;
        new_e.carry  = in_cout;
      end
      OP_SUB: begin
        new_e.result = in_sum;
        new_e.carry  = ~in_cout;
        new_e.ovf    = ovf_sub;
      end
      OP_SUBU: begin
        new_e.result = in_sum;
        new_e.carry  = ~in_cout;
      end
      OP_SLT: begin
        new_e.result = {{(WIDTH-1){1'b0}}, s_msb ^ ovf_sub};
        new_e.carry  = ~in_cout;
      end
      OP_SLTU: begin
        new_e.result = {{(WIDTH-1){1'b0}}, ~in_cout};
        new_e.carry  = ~in_cout;
      end
      default: begin
        new_e.illegal = 1'b1;
        new_e.wen     = 1'b0;
      end
    endcase
`ifdef ALU_OVF_TRAP_EN
    if (new_e.ovf) begin
      new_e.trap = 1'b1;
      new_e.wen  = 1'b0;
    end
`endif
    new_e.zero = (new_e.result == '0);
    new_e.neg  = new_e.result[WIDTH-1];
  end

`ifdef ALU_OVF_TRAP_EN
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (flush)                   state_d = S_RUN;
    else if (push && new_e.trap) state_d = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  assign run = (state_q == S_RUN);
`else
  assign run = 1'b1;
`endif

  assign in_ready  = rst_n && (count_q != 2'd2) && run && !flush;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // q0 is always the head; q1 only holds the second entry while count==2.
  always_comb begin
    q0_d    = q0_q;
    q1_d    = q1_q;
    count_d = count_q;
    if (flush) begin
      q0_d    = '0;
      q1_d    = '0;
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            q0_d    = new_e;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b10: begin
              q1_d    = new_e;
              count_d = 2'd2;
            end
            2'b01: begin
              q0_d    = '0;
              count_d = 2'd0;
            end
            2'b11:   q0_d = new_e;
            default: ;
          endcase
        end
        default: begin
          if (pop) begin
            q0_d    = q1_q;
            q1_d    = '0;
            count_d = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q0_q    <= '0;
      q1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      count_q <= count_d;
    end
  end

  assign out_result  = q0_q.result;
  assign out_tag     = q0_q.tag;
  assign out_zero    = q0_q.zero;
  assign out_neg     = q0_q.neg;
  assign out_carry   = q0_q.carry;
  assign out_ovf     = q0_q.ovf;
  assign out_wen     = q0_q.wen;
  assign out_illegal = q0_q.illegal;
  assign out_trap    = q0_q.trap;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors push expectations, a monitor checks pops.
module tb_alu_result_stage;

  logic        clk = 0;
  logic        rst_n, flush, in_valid, in_ready, in_cout;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, in_sum;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_zero, out_neg, out_carry, out_ovf, out_wen, out_illegal, out_trap;

  int checks = 0;
  int errors = 0;
  logic [43:0] sb[$];

  alu_result_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_cout(in_cout), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_wen(out_wen), .out_illegal(out_illegal), .out_trap(out_trap)
  );

  always #5 clk = ~clk;

  // {result, tag, zero, neg, carry, ovf, wen, illegal, trap}
  function automatic logic [43:0] ex(input logic [31:0] r, input logic [4:0] t,
      input logic z, input logic n, input logic c, input logic o,
      input logic w, input logic il, input logic tr);
    return {r, t, z, n, c, o, w, il, tr};
  endfunction

  function automatic logic [43:0] got();
    return {out_result, out_tag, out_zero, out_neg, out_carry, out_ovf,
            out_wen, out_illegal, out_trap};
  endfunction

  task automatic chk(input string name, input logic [43:0] act, input logic [43:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %h expected none", got());
      end else begin
        chk("pop_entry", got(), sb.pop_front());
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the entry.
  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] s, input logic co, input logic [4:0] t, input logic [43:0] e);
    int n = 0;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_sum = s; in_cout = co; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 tag %0d", t);
    end else begin
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_empty", 44'(sb.size()), 44'd0);
  endtask

  logic [43:0] e_addovf;

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_op = 0; in_a = 0; in_b = 0; in_sum = 0; in_cout = 0; in_tag = 0;
`ifdef ALU_OVF_TRAP_EN
    e_addovf = ex(32'h8000_0000, 5'd1, 0, 1, 0, 1, 0, 0, 1);
`else
    e_addovf = ex(32'h8000_0000, 5'd1, 0, 1, 0, 1, 1, 0, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", got(), 44'd0);
    chk("reset_in_ready", 44'(in_ready), 44'd0);
    chk("reset_out_valid", 44'(out_valid), 44'd0);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_in_ready", 44'(in_ready), 44'd1);
    @(posedge clk); #1;

    // Directed vectors, downstream always ready
    out_ready = 1;
    push(3'b011, 32'd5, 32'd5, 32'd0, 1, 5'd2, ex(32'd0, 5'd2, 1, 0, 0, 0, 1, 0, 0));
    push(3'b100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1, 5'd3, ex(32'd1, 5'd3, 0, 0, 0, 0, 1, 0, 0));
    push(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1, 5'd4, ex(32'd0, 5'd4, 1, 0, 0, 0, 1, 0, 0));
    push(3'b100, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1, 5'd5, ex(32'd1, 5'd5, 0, 0, 0, 0, 1, 0, 0));
    push(3'b001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 5'd6, ex(32'd0, 5'd6, 1, 0, 1, 0, 1, 0, 0));
    push(3'b110, 32'd3, 32'd4, 32'd7, 0, 5'd7, ex(32'd0, 5'd7, 1, 0, 0, 0, 0, 1, 0));
    push(3'b010, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 5'd8, ex(32'hFFFF_FFFE, 5'd8, 0, 1, 1, 0, 1, 0, 0));
    push(3'b000, 32'd1, 32'd2, 32'd3, 0, 5'd9, ex(32'd3, 5'd9, 0, 0, 0, 0, 1, 0, 0));
    drain();

    // Backpressure: three back-to-back pushes with downstream stalled
    out_ready = 0;
    push(3'b000, 32'd10, 32'd1, 32'd11, 0, 5'd10, ex(32'd11, 5'd10, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    chk("latency_out_valid", 44'(out_valid), 44'd1);
    chk("latency_head", got(), ex(32'd11, 5'd10, 0, 0, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    push(3'b000, 32'd20, 32'd1, 32'd21, 0, 5'd11, ex(32'd21, 5'd11, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    chk("full_in_ready", 44'(in_ready), 44'd0);
    chk("full_head_stable", got(), ex(32'd11, 5'd10, 0, 0, 0, 0, 1, 0, 0));
    @(posedge clk); #1;
    out_ready = 1;
    push(3'b000, 32'd30, 32'd1, 32'd31, 0, 5'd12, ex(32'd31, 5'd12, 0, 0, 0, 0, 1, 0, 0));
    drain();

    // Streaming at count 1: push and pop in the same cycle
    for (int i = 0; i < 11; i++) begin
      push(3'b000, 32'(i), 32'd1, 32'(i + 1), 0, 5'(i + 13),
           ex(32'(i + 1), 5'(i + 13), 0, 0, 0, 0, 1, 0, 0));
      if (i > 0) chk("stream_out_valid", 44'(out_valid), 44'd1);
    end
    drain();

    // Flush with two entries queued
    out_ready = 0;
    push(3'b000, 32'd1, 32'd1, 32'd2, 0, 5'd1, ex(32'd2, 5'd1, 0, 0, 0, 0, 1, 0, 0));
    push(3'b000, 32'd2, 32'd1, 32'd3, 0, 5'd2, ex(32'd3, 5'd2, 0, 0, 0, 0, 1, 0, 0));
    flush = 1;
    in_valid = 1;
    @(negedge clk);
    chk("flush_in_ready", 44'(in_ready), 44'd0);
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 44'(out_valid), 44'd0);
    chk("flush_in_ready_after", 44'(in_ready), 44'd1);
    @(posedge clk); #1;

    // Reset with two entries queued
    push(3'b000, 32'd4, 32'd1, 32'd5, 0, 5'd3, ex(32'd5, 5'd3, 0, 0, 0, 0, 1, 0, 0));
    push(3'b000, 32'd5, 32'd1, 32'd6, 0, 5'd4, ex(32'd6, 5'd4, 0, 0, 0, 0, 1, 0, 0));
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    chk("midreset_outputs", got(), 44'd0);
    chk("midreset_out_valid", 44'(out_valid), 44'd0);
    chk("midreset_in_ready", 44'(in_ready), 44'd0);
    rst_n = 1;
    @(negedge clk);
    chk("midreset_in_ready_after", 44'(in_ready), 44'd1);
    @(posedge clk); #1;

    // Signed overflow on ADD
`ifdef ALU_OVF_TRAP_EN
    out_ready = 0;
    push(3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 5'd1, e_addovf);
    repeat (3) @(negedge clk);
    chk("halt_in_ready", 44'(in_ready), 44'd0);
    out_ready = 1;
    drain();
    chk("halt_after_drain", 44'(in_ready), 44'd0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("halt_cleared", 44'(in_ready), 44'd1);
`else
    out_ready = 1;
    push(3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 0, 5'd1, e_addovf);
    drain();
    chk("ovf_no_halt", 44'(in_ready), 44'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
